// File: rtl/display_sequencer_pkg.sv
// Shared types for the display sequencer: FSM encoding, controller state names,
// and the hex-to-7-segment table (active-low {g,f,e,d,c,b,a}).
package display_sequencer_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_FINISH} disp_state_e;

  // Controller-side state flags; this block only sees the display flag as a level.
  typedef enum logic [1:0] {CTRL_IDLE, CTRL_LOAD, CTRL_COMPUTE, CTRL_DISPLAY} ctrl_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Entry [n] is the pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    return HEX_SEG[h];
  endfunction

endpackage

// File: rtl/display_sequencer_seg7_scan.sv
// Multiplexed 4-digit 7-seg driver: walks the anodes while disp_valid is high,
// otherwise blanks the display and parks the scan at digit 0.
module display_sequencer_seg7_scan
  import display_sequencer_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SCAN_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] disp_data,
  input  logic              disp_valid,
  output logic [6:0]        seg,
  output logic [3:0]        an
);
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  always_comb begin
    scan_cnt_d = scan_cnt_q;
    idx_d      = idx_q;
    seg_d      = SEG_BLANK;
    an_d       = AN_OFF;
    if (disp_valid) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex_to_seg(disp_data[{idx_q, 2'b00} +: 4]);
      if (scan_cnt_q == SW'(SCAN_CYCLES - 1)) begin
        scan_cnt_d = '0;
        idx_d      = idx_q + 2'd1;
      end else begin
        scan_cnt_d = scan_cnt_q + SW'(1);
      end
    end else begin
      scan_cnt_d = '0;
      idx_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= AN_OFF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: rtl/display_sequencer.sv
// Pages through the SA result buffer while the controller is in its display state,
// auto-advancing on a hold timer or on a next_btn rising edge, then reports done.
module display_sequencer
  import display_sequencer_pkg::*;
#(
  parameter int NUM_PAGES   = 4,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 50000000,
  parameter int SCAN_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              state_display,
  input  logic              result_wr_en,
  input  logic [1:0]        result_wr_addr,
  input  logic [DATA_W-1:0] result_wr_data,
  input  logic              next_btn,
  output logic [2:0]        current_display,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic [6:0]        seg,
  output logic [3:0]        an
);
  localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES);

  disp_state_e       state_q, state_d;
  logic [PW-1:0]     page_q, page_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              btn_prev_q;
  logic [DATA_W-1:0] pbuf_q [NUM_PAGES];
  logic [DATA_W-1:0] pbuf_d [NUM_PAGES];
  logic [2:0]        cur_q, cur_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              btn_rise, advance;

  assign btn_rise = next_btn & ~btn_prev_q;
  assign advance  = (hold_q == HW'(HOLD_CYCLES - 1)) | btn_rise;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    hold_d  = hold_q;
    pbuf_d  = pbuf_q;
    case (state_q)
      ST_IDLE: if (state_display) begin
        state_d = ST_SHOW;
        page_d  = '0;
        hold_d  = '0;
      end
      ST_SHOW: begin
        // Losing the display flag aborts regardless of a pending advance.
        if (!state_display) begin
          state_d = ST_IDLE;
          page_d  = '0;
          hold_d  = '0;
        end else if (advance) begin
          hold_d = '0;
          if (page_q == PW'(NUM_PAGES - 1)) begin
            state_d = ST_FINISH;
            page_d  = '0;
          end else begin
            page_d = page_q + PW'(1);
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (result_wr_en && (int'(result_wr_addr) < NUM_PAGES))
      pbuf_d[result_wr_addr] = result_wr_data;

    // Outputs trail the state by one register stage.
    cur_d  = (state_q == ST_SHOW)   ? 3'(page_q) :
             (state_q == ST_FINISH) ? 3'(NUM_PAGES) : 3'd0;
    vld_d  = (state_q == ST_SHOW);
    data_d = pbuf_q[page_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      page_q     <= '0;
      hold_q     <= '0;
      btn_prev_q <= 1'b0;
      for (int i = 0; i < NUM_PAGES; i++) pbuf_q[i] <= '0;
      cur_q      <= '0;
      vld_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      hold_q     <= hold_d;
      btn_prev_q <= next_btn;
      pbuf_q     <= pbuf_d;
      cur_q      <= cur_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
    end
  end

  assign current_display = cur_q;
  assign disp_valid      = vld_q;
  assign disp_data       = data_q;

  display_sequencer_seg7_scan #(.DATA_W(DATA_W), .SCAN_CYCLES(SCAN_CYCLES)) u_scan (
    .clk        (clk),
    .reset      (reset),
    .disp_data  (data_q),
    .disp_valid (vld_q),
    .seg        (seg),
    .an         (an)
  );

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer with short hold/scan periods.
module tb_display_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        state_display;
  logic        result_wr_en;
  logic [1:0]  result_wr_addr;
  logic [15:0] result_wr_data;
  logic        next_btn;
  logic [2:0]  current_display;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_err = 0;

  display_sequencer #(.NUM_PAGES(4), .DATA_W(16), .HOLD_CYCLES(8), .SCAN_CYCLES(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .state_display   (state_display),
    .result_wr_en    (result_wr_en),
    .result_wr_addr  (result_wr_addr),
    .result_wr_data  (result_wr_data),
    .next_btn        (next_btn),
    .current_display (current_display),
    .disp_data       (disp_data),
    .disp_valid      (disp_valid),
    .seg             (seg),
    .an              (an)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        sd;
    int          n;
    logic [2:0]  cd;
    logic        v;
    logic [15:0] d;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_out();
    state_display = 1'b0;
    tick();
    tick();
    chk("idle_cd", 32'(current_display), 0);
    chk("idle_valid", 32'(disp_valid), 0);
  endtask

  vec_t        tbl [7];
  logic [15:0] pages [4];
  logic [3:0]  exp_an [8];
  logic [6:0]  exp_seg [8];

  initial begin
    tbl[0] = '{1'b1, 1, 3'd0, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 8, 3'd0, 1'b1, 16'h1234};
    tbl[2] = '{1'b1, 8, 3'd1, 1'b1, 16'hABCD};
    tbl[3] = '{1'b1, 8, 3'd2, 1'b1, 16'h0F0F};
    tbl[4] = '{1'b1, 8, 3'd3, 1'b1, 16'hBEEF};
    tbl[5] = '{1'b1, 1, 3'd4, 1'b0, 16'h0000};
    tbl[6] = '{1'b0, 1, 3'd0, 1'b0, 16'h0000};
    pages   = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hBEEF};
    exp_an  = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};
    exp_seg = '{7'h19, 7'h19, 7'h30, 7'h30, 7'h24, 7'h24, 7'h79, 7'h79};

    reset = 1'b1; state_display = 1'b0; result_wr_en = 1'b0;
    result_wr_addr = 2'd0; result_wr_data = 16'h0; next_btn = 1'b0;
    tick();
    tick();
    chk("rst_cd", 32'(current_display), 0);
    chk("rst_valid", 32'(disp_valid), 0);
    chk("rst_data", 32'(disp_data), 0);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      result_wr_en = 1'b1; result_wr_addr = 2'(i); result_wr_data = pages[i];
      tick();
    end
    result_wr_en = 1'b0;
    tick();

    // Full auto-advance run through all pages
    for (int r = 0; r < 7; r++) begin
      state_display = tbl[r].sd;
      for (int c = 0; c < tbl[r].n; c++) begin
        tick();
        chk($sformatf("run%0d_cd", r), 32'(current_display), 32'(tbl[r].cd));
        chk($sformatf("run%0d_valid", r), 32'(disp_valid), 32'(tbl[r].v));
        if (tbl[r].v) chk($sformatf("run%0d_data", r), 32'(disp_data), 32'(tbl[r].d));
      end
    end
    idle_out();

    // Button pulse on page 0, held 5 cycles: one advance, hold restarts
    state_display = 1'b1;
    tick(); tick(); tick();
    chk("btn_pre_cd", 32'(current_display), 0);
    next_btn = 1'b1;
    tick();
    chk("btn_edge_cd", 32'(current_display), 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("btn_held_cd", 32'(current_display), 1);
    end
    next_btn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("btn_hold_cd", 32'(current_display), 1);
    end
    tick();
    chk("btn_expire_cd", 32'(current_display), 2);
    idle_out();

    // Button edge coincident with hold expiry on page 1
    state_display = 1'b1;
    tick();
    for (int c = 0; c < 15; c++) tick();
    chk("coin_pre_cd", 32'(current_display), 1);
    next_btn = 1'b1;
    tick();
    chk("coin_edge_cd", 32'(current_display), 1);
    next_btn = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("coin_p2_cd", 32'(current_display), 2);
    end
    tick();
    chk("coin_p3_cd", 32'(current_display), 3);
    idle_out();

    // Abort during page 1, then re-entry and anode scan
    state_display = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("abort_p1_cd", 32'(current_display), 1);
    tick();
    state_display = 1'b0;
    tick();
    chk("abort_lag_valid", 32'(disp_valid), 1);
    tick();
    chk("abort_cd", 32'(current_display), 0);
    chk("abort_valid", 32'(disp_valid), 0);
    tick();
    chk("abort_an", 32'(an), 32'hF);
    chk("abort_seg", 32'(seg), 32'h7F);
    state_display = 1'b1;
    tick();
    tick();
    chk("reent_cd", 32'(current_display), 0);
    chk("reent_valid", 32'(disp_valid), 1);
    chk("reent_data", 32'(disp_data), 32'h1234);
    chk("reent_an_off", 32'(an), 32'hF);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("scan%0d_an", c), 32'(an), 32'(exp_an[c]));
      chk($sformatf("scan%0d_seg", c), 32'(seg), 32'(exp_seg[c]));
    end
    idle_out();

    // Write to the page on display
    state_display = 1'b1;
    tick();
    tick();
    chk("wr_before", 32'(disp_data), 32'h1234);
    result_wr_en = 1'b1; result_wr_addr = 2'd0; result_wr_data = 16'h5678;
    tick();
    result_wr_en = 1'b0;
    chk("wr_same_cycle", 32'(disp_data), 32'h1234);
    tick();
    chk("wr_after", 32'(disp_data), 32'h5678);

    // Reset mid-SHOW on page 2
    for (int c = 0; c < 14; c++) tick();
    chk("mid_cd", 32'(current_display), 2);
    chk("mid_data", 32'(disp_data), 32'h0F0F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_cd", 32'(current_display), 0);
    chk("mrst_valid", 32'(disp_valid), 0);
    chk("mrst_an", 32'(an), 32'hF);
    chk("mrst_seg", 32'(seg), 32'h7F);
    chk("mrst_data", 32'(disp_data), 0);
    tick();
    tick();
    chk("mrst_reent_valid", 32'(disp_valid), 1);
    chk("mrst_buf", 32'(disp_data), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
